// File: rtl/data_sram_responder.sv
`default_nettype none
// data_sram_responder: never-stalling, one-cycle-latency responder for the core's data SRAM port.
// Decodes each access to a byte-writable word RAM or an LED/switch/timer/scratch register page.
module data_sram_responder #(
   parameter int          RAM_AW    = 12,
   parameter logic [15:0] CONF_HI   = 16'hBFAF,
   parameter logic [31:0] TIMER_RST = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   input  logic [15:0] switch_in,
   output logic [15:0] led_out
);

   localparam logic [13:0] OFF_LED     = 14'd0;
   localparam logic [13:0] OFF_SWITCH  = 14'd1;
   localparam logic [13:0] OFF_TIMER   = 14'd2;
   localparam logic [13:0] OFF_SCRATCH = 14'd3;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = old_w;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
      end
      return res;
   endfunction

   logic              w_page;
   logic [13:0]       w_off;
   logic              w_wr;
   logic [RAM_AW-1:0] w_idx;
   logic              w_ram_we;
   logic              w_unused_addr;

   assign w_page        = (data_sram_addr[31:16] == CONF_HI);
   assign w_off         = data_sram_addr[15:2];
   assign w_idx         = data_sram_addr[RAM_AW+1:2];
   assign w_wr          = data_sram_en & (|data_sram_wen);
   // The RAM has no reset of its own, so a store overlapping reset must be blocked here.
   assign w_ram_we      = rst & w_wr & ~w_page;
   assign w_unused_addr = ^data_sram_addr[1:0];

   logic [31:0] mem_q [2**RAM_AW];
   logic [31:0] ram_rd_q;

   always_ff @(posedge clk) begin
      if (data_sram_en) ram_rd_q <= mem_q[w_idx];
      for (int b = 0; b < 4; b++) begin
         if (w_ram_we && data_sram_wen[b]) mem_q[w_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
   end

   logic [15:0] led_q,     led_d;
   logic [31:0] scratch_q, scratch_d;
   logic [31:0] timer_q,   timer_d;
   logic [31:0] page_rd_q, page_rd_d;
   logic        src_page_q, src_page_d;
   logic        live_q;

   always_comb begin
      led_d      = led_q;
      scratch_d  = scratch_q;
      timer_d    = timer_q + 32'd1;
      page_rd_d  = page_rd_q;
      src_page_d = src_page_q;

      if (data_sram_en) begin
         src_page_d = w_page;
         if (w_page) begin
            case (w_off)
               OFF_LED:     page_rd_d = {16'h0, led_q};
               OFF_SWITCH:  page_rd_d = {16'h0, switch_in};
               OFF_TIMER:   page_rd_d = timer_q;
               OFF_SCRATCH: page_rd_d = scratch_q;
               default:     page_rd_d = 32'h0;
            endcase
         end
      end

      if (w_wr && w_page) begin
         case (w_off)
            OFF_LED: begin
               if (data_sram_wen[0]) led_d[7:0]  = data_sram_wdata[7:0];
               if (data_sram_wen[1]) led_d[15:8] = data_sram_wdata[15:8];
            end
            OFF_TIMER:   timer_d   = merge_bytes(timer_q, data_sram_wdata, data_sram_wen);
            OFF_SCRATCH: scratch_d = merge_bytes(scratch_q, data_sram_wdata, data_sram_wen);
            default: ;
         endcase
      end

      // First edge after reset release presents zero regardless of the request.
      if (!live_q) begin
         page_rd_d  = 32'h0;
         src_page_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         led_q      <= 16'h0;
         scratch_q  <= 32'h0;
         timer_q    <= TIMER_RST;
         page_rd_q  <= 32'h0;
         src_page_q <= 1'b1;
         live_q     <= 1'b0;
      end else begin
         led_q      <= led_d;
         scratch_q  <= scratch_d;
         timer_q    <= timer_d;
         page_rd_q  <= page_rd_d;
         src_page_q <= src_page_d;
         live_q     <= 1'b1;
      end
   end

   assign data_sram_rdata = src_page_q ? page_rd_q : ram_rd_q;
   assign led_out         = led_q;

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// tb_data_sram_responder: directed and random accesses scored against a behavioural model.
module tb_data_sram_responder;

   localparam logic [15:0] CONF_HI = 16'hBFAF;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        data_sram_en = 1'b0;
   logic [3:0]  data_sram_wen = 4'h0;
   logic [31:0] data_sram_addr = 32'h0;
   logic [31:0] data_sram_wdata = 32'h0;
   logic [31:0] data_sram_rdata;
   logic [15:0] switch_in = 16'h0;
   logic [15:0] led_out;

   always #5 clk = ~clk;

   data_sram_responder #(.RAM_AW(12), .CONF_HI(CONF_HI), .TIMER_RST(32'h0)) dut (
      .clk             (clk),
      .rst             (rst),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .switch_in       (switch_in),
      .led_out         (led_out)
   );

   typedef struct {
      logic        chk;
      logic [31:0] rd;
      logic [15:0] led;
   } exp_t;

   exp_t expq[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state
   logic [31:0] m_ram [int unsigned];
   logic [15:0] m_led;
   logic [31:0] m_scratch;
   logic [31:0] m_timer;
   logic [31:0] m_rd;
   logic        m_known;
   logic        m_first;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
      return r;
   endfunction

   task automatic model_reset();
      m_led     = 16'h0;
      m_scratch = 32'h0;
      m_timer   = 32'h0;
      m_rd      = 32'h0;
      m_known   = 1'b1;
      m_first   = 1'b1;
   endtask

   // Called at a falling edge; drives one cycle and returns at the next falling edge.
   task automatic access(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
      logic        page;
      logic [15:0] off;
      int unsigned idx;
      logic [31:0] nt;
      exp_t        e;
      data_sram_en    = en;
      data_sram_wen   = wen;
      data_sram_addr  = addr;
      data_sram_wdata = wdata;
      page = (addr[31:16] == CONF_HI);
      off  = addr[15:0] & 16'hFFFC;
      idx  = (addr >> 2) & 32'hFFF;
      if (en) begin
         m_known = 1'b1;
         if (page) begin
            case (off)
               16'h0000: m_rd = {16'h0, m_led};
               16'h0004: m_rd = {16'h0, switch_in};
               16'h0008: m_rd = m_timer;
               16'h000C: m_rd = m_scratch;
               default:  m_rd = 32'h0;
            endcase
         end else if (m_ram.exists(idx)) begin
            m_rd = m_ram[idx];
         end else begin
            m_known = 1'b0;
         end
      end
      if (m_first) begin
         m_rd    = 32'h0;
         m_known = 1'b1;
      end
      nt = m_timer + 32'd1;
      if (en && wen != 4'h0) begin
         if (page) begin
            case (off)
               16'h0000: begin
                  if (wen[0]) m_led[7:0]  = wdata[7:0];
                  if (wen[1]) m_led[15:8] = wdata[15:8];
               end
               16'h0008: nt = merge(m_timer, wdata, wen);
               16'h000C: m_scratch = merge(m_scratch, wdata, wen);
               default: ;
            endcase
         end else if (m_ram.exists(idx)) begin
            m_ram[idx] = merge(m_ram[idx], wdata, wen);
         end else if (wen == 4'hF) begin
            m_ram[idx] = wdata;
         end
      end
      m_timer = nt;
      m_first = 1'b0;
      e.chk = m_known;
      e.rd  = m_rd;
      e.led = m_led;
      expq.push_back(e);
      @(negedge clk);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            if (e.chk) check("rdata", data_sram_rdata, e.rd);
            check("led_out", {16'h0, led_out}, {16'h0, e.led});
         end
      end
   end

   initial begin : stim
      logic [15:0] offs [6];
      offs = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0020, 16'h0010};
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_rdata", data_sram_rdata, 32'h0);
      check("reset_led", {16'h0, led_out}, 32'h0);
      rst = 1'b1;
      access(1'b1, 4'h0, 32'h0000_0010, 32'h0);
      repeat (5) access(1'b0, 4'h0, 32'h0, 32'h0);
      access(1'b1, 4'h0, 32'hBFAF_0008, 32'h0);

      // Byte-lane merge in RAM
      access(1'b1, 4'hF, 32'h0000_0040, 32'h1122_3344);
      access(1'b1, 4'b0101, 32'h0000_0040, 32'hAABB_CCDD);
      access(1'b1, 4'h0, 32'h0000_0040, 32'h0);
      access(1'b0, 4'h0, 32'h0, 32'h0);
      check("merge_word", m_ram[32'h10], 32'h11BB_33DD);

      // Timer wrap
      access(1'b1, 4'hF, 32'hBFAF_0008, 32'hFFFF_FFFE);
      repeat (3) access(1'b1, 4'h0, 32'hBFAF_0008, 32'h0);

      // LED / switch / unmapped offsets
      access(1'b1, 4'hF, 32'hBFAF_0000, 32'h0000_ABCD);
      access(1'b1, 4'hF, 32'hBFAF_0004, 32'hFFFF_FFFF);
      switch_in = 16'h00F0;
      access(1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
      access(1'b1, 4'hF, 32'hBFAF_0020, 32'h1234_5678);
      access(1'b1, 4'h0, 32'hBFAF_0020, 32'h0);
      access(1'b1, 4'h0, 32'hBFAF_0000, 32'h0);

      // Read-before-write and hold
      access(1'b1, 4'hF, 32'h0000_0080, 32'h5);
      access(1'b1, 4'hF, 32'h0000_0080, 32'h9);
      access(1'b1, 4'h0, 32'h0000_0080, 32'h0);
      repeat (3) access(1'b0, 4'h0, 32'h0, 32'h0);

      // Random traffic over a small RAM window (aliased upper bits) and the register page
      for (int i = 0; i < 16; i++) access(1'b1, 4'hF, i << 2, $urandom);
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         logic [3:0]  w;
         logic        en;
         switch_in = 16'($urandom);
         en = ($urandom_range(0, 3) != 0);
         w  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         if ($urandom_range(0, 2) == 0) begin
            a = {CONF_HI, offs[$urandom_range(0, 5)]} | 32'($urandom_range(0, 3));
         end else begin
            a = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            if (a[31:16] == CONF_HI) a[31] = ~a[31];
         end
         access(en, w, a, $urandom);
      end

      // Reset asserted in the middle of a scratch store
      access(1'b1, 4'hF, 32'hBFAF_000C, 32'hCAFE_0001);
      access(1'b1, 4'hF, 32'hBFAF_0000, 32'h0000_5A5A);
      data_sram_en    = 1'b1;
      data_sram_wen   = 4'hF;
      data_sram_addr  = 32'hBFAF_000C;
      data_sram_wdata = 32'h0000_0077;
      #2 rst = 1'b0;
      #1;
      check("async_rdata", data_sram_rdata, 32'h0);
      check("async_led", {16'h0, led_out}, 32'h0);
      data_sram_en  = 1'b0;
      data_sram_wen = 4'h0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      model_reset();
      access(1'b1, 4'h0, 32'hBFAF_000C, 32'h0);
      access(1'b1, 4'h0, 32'hBFAF_000C, 32'h0);
      access(1'b1, 4'h0, 32'h0000_0080, 32'h0);
      access(1'b0, 4'h0, 32'h0, 32'h0);

      repeat (2) @(negedge clk);
      check("queue_drained", 32'(expq.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
